// File: rtl/sram_pkg.sv
// Shared types and default constants for the external SRAM arbiter.
// The state encoding, grant codes and default geometry are used by
// sram_arbiter and sram_arb_pick.
package sram_pkg;

   localparam int SRAM_ADDR_W      = 18;
   localparam int SRAM_WAIT_CYCLES = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      DONE   = 3'd3,
      TURN   = 3'd4
   } sram_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_MON  = 2'd2
   } sram_gnt_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selector for the SRAM arbiter.
// Default build: strict CPU-over-monitor priority, no state.
// With SRAM_ARB_RR_EN defined: round-robin tie-break using a last-grant
// register that is updated at every grant.
module sram_arb_pick
   import sram_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
   input  logic      clock,
   input  logic      reset_n,
   input  logic      grant_en,
`endif
   input  logic      c_req,
   input  logic      m_req,
   output sram_gnt_t gnt
);

`ifdef SRAM_ARB_RR_EN
   sram_gnt_t last_gnt_r;

   // On a tie the requester that was not served last wins
   always_comb begin
      gnt = GNT_NONE;
      if (c_req && m_req) begin
         if (last_gnt_r == GNT_MON) begin
            gnt = GNT_CPU;
         end else begin
            gnt = GNT_MON;
         end
      end else if (c_req) begin
         gnt = GNT_CPU;
      end else if (m_req) begin
         gnt = GNT_MON;
      end else begin
         gnt = GNT_NONE;
      end
   end

   // Remember the port granted most recently; reset favours the CPU on the first tie
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_r <= GNT_MON;
      end else if (grant_en && (gnt != GNT_NONE)) begin
         last_gnt_r <= gnt;
      end else begin
         last_gnt_r <= last_gnt_r;
      end
   end
`else
   // Fixed priority: the monitor only wins when the CPU is not asking
   always_comb begin
      gnt = GNT_NONE;
      if (c_req) begin
         gnt = GNT_CPU;
      end else if (m_req) begin
         gnt = GNT_MON;
      end else begin
         gnt = GNT_NONE;
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shared external SRAM sequencer and two-port arbiter (CPU port c, monitor
// port m). Owns all strobe timing: IDLE -> SETUP -> ACCESS (WAIT_CYCLES)
// -> DONE -> TURN -> IDLE. All SRAM pins and handshake outputs are registered.
// Optional build macro: SRAM_ARB_RR_EN selects round-robin arbitration.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [7:0]        c_wdata,
   output logic [7:0]        c_rdata,
   output logic              c_ack,
   input  logic              m_req,
   input  logic              m_we,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [7:0]        m_wdata,
   output logic [7:0]        m_rdata,
   output logic              m_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [7:0]        sram_dout,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_din,
   output logic              busy
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   sram_state_t       state_r;
   sram_gnt_t         gnt_r;
   logic              we_r;
   logic [3:0]        cnt_r;

   sram_gnt_t         pick_s;
   logic              win_we_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [7:0]        win_wdata_s;

`ifdef SRAM_ARB_RR_EN
   logic              grant_en_s;

   assign grant_en_s = (state_r == IDLE);
`endif

   sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
      .clock    (clock),
      .reset_n  (reset_n),
      .grant_en (grant_en_s),
`endif
      .c_req    (c_req),
      .m_req    (m_req),
      .gnt      (pick_s)
   );

   // Route the winning requester's access parameters to the latch point
   always_comb begin
      win_we_s    = 1'b0;
      win_addr_s  = {ADDR_W{1'b0}};
      win_wdata_s = 8'h00;
      case (pick_s)
         GNT_CPU: begin
            win_we_s    = c_we;
            win_addr_s  = c_addr;
            win_wdata_s = c_wdata;
         end
         GNT_MON: begin
            win_we_s    = m_we;
            win_addr_s  = m_addr;
            win_wdata_s = m_wdata;
         end
         default: begin
            win_we_s    = 1'b0;
            win_addr_s  = {ADDR_W{1'b0}};
            win_wdata_s = 8'h00;
         end
      endcase
   end

   // Access sequencer: every strobe is set on the edge that enters the state it belongs to
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         gnt_r      <= GNT_NONE;
         we_r       <= 1'b0;
         cnt_r      <= 4'd0;
         sram_addr  <= {ADDR_W{1'b0}};
         sram_dout  <= 8'h00;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_dq_oe <= 1'b0;
         c_ack      <= 1'b0;
         m_ack      <= 1'b0;
         c_rdata    <= 8'h00;
         m_rdata    <= 8'h00;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               c_ack <= 1'b0;
               m_ack <= 1'b0;
               if (pick_s != GNT_NONE) begin
                  // Latch the winner; address, data and direction stay fixed to TURN
                  gnt_r      <= pick_s;
                  we_r       <= win_we_s;
                  sram_addr  <= win_addr_s;
                  sram_dout  <= win_wdata_s;
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= win_we_s;
                  sram_dq_oe <= win_we_s;
                  busy       <= 1'b1;
                  state_r    <= SETUP;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               sram_we_n <= ~we_r;
               cnt_r     <= WAIT_LD;
               state_r   <= ACCESS;
            end
            ACCESS: begin
               if (cnt_r <= 4'd1) begin
                  // Last strobe cycle: read data is sampled here so it is valid with ack
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  state_r   <= DONE;
                  case (gnt_r)
                     GNT_CPU: begin
                        c_ack <= 1'b1;
                        if (!we_r) begin
                           c_rdata <= sram_din;
                        end else begin
                           c_rdata <= c_rdata;
                        end
                     end
                     GNT_MON: begin
                        m_ack <= 1'b1;
                        if (!we_r) begin
                           m_rdata <= sram_din;
                        end else begin
                           m_rdata <= m_rdata;
                        end
                     end
                     default: begin
                        c_ack <= 1'b0;
                        m_ack <= 1'b0;
                     end
                  endcase
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            DONE: begin
               // Release the chip and the data bus a full cycle before the next SETUP
               c_ack      <= 1'b0;
               m_ack      <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               gnt_r      <= GNT_NONE;
               state_r    <= TURN;
            end
            TURN: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               c_ack      <= 1'b0;
               m_ack      <= 1'b0;
               gnt_r      <= GNT_NONE;
               busy       <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed steps from the test plan
// followed by randomized single and contending accesses, checked against a
// transaction-level model (expected memory, grant order, ack latency).
// Build with SRAM_ARB_RR_EN defined to check the round-robin variant.
module tb_sram_arbiter;

   localparam int AW    = 18;
   localparam int MEMSZ = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          c_req, c_we, m_req, m_we;
   logic [AW-1:0] c_addr, m_addr;
   logic [7:0]    c_wdata, m_wdata;
   logic [7:0]    c_rdata, m_rdata;
   logic          c_ack, m_ack;
   logic [AW-1:0] sram_addr;
   logic          sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
   logic [7:0]    sram_dout;
   logic [7:0]    sram_din = 8'hEE;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;

   logic [7:0]    dev_mem [0:MEMSZ-1];
   bit            dev_wr  [0:MEMSZ-1];
   logic [7:0]    ref_mem [logic [AW-1:0]];
   bit            last_mon;
   logic          prev_ack_r = 1'b0;

   int            c_cyc, m_cyc, we_low, extra, busy_cnt, n_got, mode;
   logic [7:0]    c_rd, m_rd, exp_c, exp_m;
   bit            dq_seen, first_mon, cw, mw;
   logic [AW-1:0] ca, ma;
   logic [7:0]    cd, md;
   int            got_mon [4];
   int            got_cyc [4];
   int            exp_mon;

   sram_arbiter dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .c_req      (c_req),
      .c_we       (c_we),
      .c_addr     (c_addr),
      .c_wdata    (c_wdata),
      .c_rdata    (c_rdata),
      .c_ack      (c_ack),
      .m_req      (m_req),
      .m_we       (m_we),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_rdata    (m_rdata),
      .m_ack      (m_ack),
      .sram_addr  (sram_addr),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sram_dout  (sram_dout),
      .sram_dq_oe (sram_dq_oe),
      .sram_din   (sram_din),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // Power-up content of the SRAM: location 0 holds 0xC3
   function automatic logic [7:0] dflt(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hC3;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // SRAM device model: writes commit while we_n is low, data appears while oe_n is low
   always @(negedge clock) begin
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         dev_mem[sram_addr] <= sram_dout;
         dev_wr[sram_addr]  <= 1'b1;
      end
      if (!sram_ce_n && !sram_oe_n) begin
         sram_din <= dev_wr[sram_addr] ? dev_mem[sram_addr] : dflt(sram_addr);
      end else begin
         sram_din <= 8'hEE;
      end
   end

   // Bus turnaround: the cycle after any ack must have ce_n high and the bus released
   always @(negedge clock) begin
      if (prev_ack_r) begin
         check("turn_ce_n", {31'd0, sram_ce_n}, 32'd1);
         check("turn_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      end
      prev_ack_r <= c_ack | m_ack;
   end

   // Model: apply one access to the expected memory and record the grant
   task automatic model_apply(input bit is_mon, input bit w, input logic [AW-1:0] a,
                              input logic [7:0] d, output logic [7:0] rd_exp);
      if (w) begin
         ref_mem[a] = d;
         rd_exp     = 8'h00;
      end else begin
         rd_exp = ref_rd(a);
      end
      last_mon = is_mon;
   endtask

   // Model: who wins when both ports ask in the same IDLE cycle
   function automatic bit tie_winner_mon();
`ifdef SRAM_ARB_RR_EN
      return !last_mon;
`else
      return 1'b0;
`endif
   endfunction

   // Present requests in an IDLE cycle (cycle 0) and collect ack cycles / read data
   task automatic txn(input bit c_on, input bit c_w, input logic [AW-1:0] c_a, input logic [7:0] c_d,
                      input bit m_on, input bit m_w, input logic [AW-1:0] m_a, input logic [7:0] m_d,
                      input bit drop_c,
                      output int oc_cyc, output int om_cyc, output logic [7:0] oc_rd,
                      output logic [7:0] om_rd, output int owe_low, output bit odq);
      bit c_pend, m_pend;
      c_we = c_w; c_addr = c_a; c_wdata = c_d;
      m_we = m_w; m_addr = m_a; m_wdata = m_d;
      c_req = c_on; m_req = m_on;
      c_pend = c_on; m_pend = m_on;
      oc_cyc = -1; om_cyc = -1; oc_rd = 8'h00; om_rd = 8'h00; owe_low = 0; odq = 1'b0;
      for (int k = 0; k < 40 && (c_pend || m_pend); k++) begin
         @(negedge clock);
         if (c_ack && c_pend) begin oc_cyc = k; oc_rd = c_rdata; c_pend = 1'b0; end
         if (m_ack && m_pend) begin om_cyc = k; om_rd = m_rdata; m_pend = 1'b0; end
         if (!sram_we_n) owe_low++;
         if (sram_dq_oe) odq = 1'b1;
         @(posedge clock); #1;
         if (drop_c && k == 0) c_req = 1'b0;
         if (!c_pend) c_req = 1'b0;
         if (!m_pend) m_req = 1'b0;
      end
      c_req = 1'b0; m_req = 1'b0;
      @(posedge clock); #1;
   endtask

   initial begin
      reset_n = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = 8'h00;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = 8'h00;
      last_mon = 1'b1;

      // ---- reset state ----
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
      check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rst_acks", {30'd0, c_ack, m_ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_addr", {14'd0, sram_addr}, 32'd0);
      check("rst_data", {8'd0, sram_dout, c_rdata, m_rdata}, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // ---- CPU write 0x5A to 0x04082, then read it back ----
      model_apply(1'b0, 1'b1, 18'h04082, 8'h5A, exp_c);
      txn(1'b1, 1'b1, 18'h04082, 8'h5A, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("wr_ack_lat", c_cyc, 32'd6);
      check("wr_we_low", we_low, 32'd4);
      check("wr_dq_oe", {31'd0, dq_seen}, 32'd1);
      check("wr_busy_idle", {31'd0, busy}, 32'd0);
      model_apply(1'b0, 1'b0, 18'h04082, 8'h00, exp_c);
      txn(1'b1, 1'b0, 18'h04082, 8'h00, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("rd_ack_lat", c_cyc, 32'd6);
      check("rd_data", {24'd0, c_rd}, {24'd0, exp_c});
      check("rd_we_low", we_low, 32'd0);

      // ---- monitor read of preloaded location 0 ----
      model_apply(1'b1, 1'b0, 18'h00000, 8'h00, exp_m);
      txn(1'b0, 1'b0, 18'h0, 8'h00, 1'b1, 1'b0, 18'h00000, 8'h00, 1'b0,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("mrd_ack_lat", m_cyc, 32'd6);
      check("mrd_data", {24'd0, m_rd}, 32'h0000_00C3);
      check("mrd_dq_oe", {31'd0, dq_seen}, 32'd0);

      // ---- simultaneous requests, each dropped after its own ack ----
      model_apply(1'b0, 1'b1, 18'h01234, 8'h11, exp_c);
      model_apply(1'b1, 1'b0, 18'h04082, 8'h00, exp_m);
      txn(1'b1, 1'b1, 18'h01234, 8'h11, 1'b1, 1'b0, 18'h04082, 8'h00, 1'b0,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("tie_c_first", c_cyc, 32'd6);
      check("tie_m_after", m_cyc, 32'd14);
      check("tie_m_data", {24'd0, m_rd}, {24'd0, exp_m});

      // ---- both requests held: grant sequence over four accesses ----
      c_we = 1'b0; c_addr = 18'h04082; m_we = 1'b0; m_addr = 18'h01234;
      c_req = 1'b1; m_req = 1'b1;
      n_got = 0;
      for (int k = 0; k < 80 && n_got < 4; k++) begin
         @(negedge clock);
         if (c_ack) begin got_mon[n_got] = 0; got_cyc[n_got] = k; n_got++; end
         if (m_ack && n_got < 4) begin got_mon[n_got] = 1; got_cyc[n_got] = k; n_got++; end
         @(posedge clock); #1;
      end
      c_req = 1'b0; m_req = 1'b0;
      @(posedge clock); #1;
      check("hold_count", n_got, 32'd4);
      for (int i = 0; i < 4; i++) begin
         exp_mon  = int'(tie_winner_mon());
         last_mon = (exp_mon != 0);
         if (i < n_got) begin
            check($sformatf("hold_grant%0d", i), got_mon[i], exp_mon);
            check($sformatf("hold_cyc%0d", i), got_cyc[i], 6 + 8 * i);
         end else begin
            check($sformatf("hold_missing%0d", i), n_got, 32'd4);
         end
      end

      // ---- CPU drops req during SETUP of a write to 0x3FFFF ----
      model_apply(1'b0, 1'b1, 18'h3FFFF, 8'h77, exp_c);
      txn(1'b1, 1'b1, 18'h3FFFF, 8'h77, 1'b0, 1'b0, 18'h0, 8'h00, 1'b1,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("drop_ack_lat", c_cyc, 32'd6);
      check("drop_we_low", we_low, 32'd4);
      extra = 0; busy_cnt = 0;
      repeat (20) begin
         @(negedge clock);
         if (c_ack || m_ack) extra++;
         if (busy) busy_cnt++;
      end
      check("drop_no_extra_ack", extra, 32'd0);
      check("drop_no_2nd_access", busy_cnt, 32'd0);
      @(posedge clock); #1;
      model_apply(1'b0, 1'b0, 18'h3FFFF, 8'h00, exp_c);
      txn(1'b1, 1'b0, 18'h3FFFF, 8'h00, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0,
          c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
      check("drop_readback", {24'd0, c_rd}, {24'd0, exp_c});

      // ---- async reset during ACCESS of a write ----
      c_we = 1'b1; c_addr = 18'h2AAAA; c_wdata = 8'h99; c_req = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #2;
      check("arst_pre_we_n", {31'd0, sram_we_n}, 32'd0);
      reset_n = 1'b0;
      c_req   = 1'b0;
      #1;
      check("arst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("arst_ce_n", {31'd0, sram_ce_n}, 32'd1);
      check("arst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      check("arst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      extra = 0;
      repeat (3) begin
         @(negedge clock);
         if (c_ack || m_ack) extra++;
      end
      reset_n  = 1'b1;
      last_mon = 1'b1;
      repeat (4) begin
         @(negedge clock);
         if (c_ack || m_ack) extra++;
      end
      check("arst_no_ack", extra, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      @(posedge clock); #1;

      // ---- randomized accesses against the transaction model ----
      for (int i = 0; i < 30; i++) begin
         mode = int'($urandom_range(0, 2));
         cw = 1'($urandom_range(0, 1));
         mw = 1'($urandom_range(0, 1));
         ca = 18'h00100 + 18'($urandom_range(0, 15)) * 18'h03000;
         ma = 18'h00100 + 18'($urandom_range(0, 15)) * 18'h03000;
         cd = 8'($urandom_range(0, 255));
         md = 8'($urandom_range(0, 255));
         if (mode == 0) begin
            model_apply(1'b0, cw, ca, cd, exp_c);
            txn(1'b1, cw, ca, cd, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0,
                c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
            check($sformatf("rnd%0d_c_lat", i), c_cyc, 32'd6);
            if (!cw) check($sformatf("rnd%0d_c_data", i), {24'd0, c_rd}, {24'd0, exp_c});
         end else if (mode == 1) begin
            model_apply(1'b1, mw, ma, md, exp_m);
            txn(1'b0, 1'b0, 18'h0, 8'h00, 1'b1, mw, ma, md, 1'b0,
                c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
            check($sformatf("rnd%0d_m_lat", i), m_cyc, 32'd6);
            if (!mw) check($sformatf("rnd%0d_m_data", i), {24'd0, m_rd}, {24'd0, exp_m});
         end else begin
            first_mon = tie_winner_mon();
            if (first_mon) begin
               model_apply(1'b1, mw, ma, md, exp_m);
               model_apply(1'b0, cw, ca, cd, exp_c);
            end else begin
               model_apply(1'b0, cw, ca, cd, exp_c);
               model_apply(1'b1, mw, ma, md, exp_m);
            end
            txn(1'b1, cw, ca, cd, 1'b1, mw, ma, md, 1'b0,
                c_cyc, m_cyc, c_rd, m_rd, we_low, dq_seen);
            check($sformatf("rnd%0d_c_lat", i), c_cyc, first_mon ? 32'd14 : 32'd6);
            check($sformatf("rnd%0d_m_lat", i), m_cyc, first_mon ? 32'd6 : 32'd14);
            if (!cw) check($sformatf("rnd%0d_c_data", i), {24'd0, c_rd}, {24'd0, exp_c});
            if (!mw) check($sformatf("rnd%0d_m_data", i), {24'd0, m_rd}, {24'd0, exp_m});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences every access to the shared 256 KiB external SRAM and arbitrates it between two requesters: the Z80/ZX81 memory path (port `c`) and the serial debug monitor (port `m`). It sits between the CPU glue and the command-line monitor on one side and the SRAM pins and tristate buffer on the other. It owns all SRAM strobe timing, including the slow-buffer wait states, so neither requester drives the SRAM directly.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM address width.
- `WAIT_CYCLES`, 4: strobe-active cycles per access, which covers the SRAM and buffers (>20 ns). The legal range is 1..15.

Ports:
- `clock` in 1: single system clock. Everything is `posedge clock`.
- `reset_n` in 1: asynchronous, active-low reset.
- `c_req` in 1: CPU access request. Held high until `c_ack`.
- `c_we` in 1: CPU access type. 1 = write, 0 = read.
- `c_addr` in ADDR_W: CPU address.
- `c_wdata` in 8: CPU write data.
- `c_rdata` out 8: CPU read data. Valid from `c_ack` until the next CPU access completes.
- `c_ack` out 1: one-cycle completion pulse for the CPU.
- `m_req` in 1: monitor access request. Held high until `m_ack`.
- `m_we` in 1: monitor access type. 1 = write, 0 = read.
- `m_addr` in ADDR_W: monitor address.
- `m_wdata` in 8: monitor write data.
- `m_rdata` out 8: monitor read data. Valid from `m_ack` until the next monitor access completes.
- `m_ack` out 1: one-cycle completion pulse for the monitor.
- `sram_addr` out ADDR_W: SRAM address pins.
- `sram_ce_n` out 1: SRAM chip enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_dout` out 8: data driven to the SRAM.
- `sram_dq_oe` out 1: 1 = FPGA drives the data bus.
- `sram_din` in 8: data read from the SRAM.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values:
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_dq_oe` = 0.
  - `c_ack`, `m_ack`, `busy` = 0.
  - `sram_addr`, `sram_dout`, `c_rdata`, `m_rdata` = 0.
  - Grant = none. The last-grant register points at the monitor, so the CPU wins the first tie.
- States:
  - IDLE: sample the requests. If any request is pending, latch the winner's `addr`, `we` and `wdata`, then go to SETUP.
  - SETUP: for one cycle, drive the address with `ce_n`=0.
    - Read: `oe_n`=0.
    - Write: `oe_n`=1 and `dq_oe`=1.
  - ACCESS: strobes held for `WAIT_CYCLES` cycles, timed by a 4-bit down-counter.
    - Write: `we_n`=0.
    - Read: `oe_n` stays at 0.
  - DONE: for one cycle, deassert `we_n`/`oe_n`.
    - Read: capture `sram_din` into the granted port's `rdata`.
    - Pulse the granted port's `ack`.
    - Keep `dq_oe` and the address stable through this cycle.
  - TURN: one cycle with `ce_n`=1 and `dq_oe`=0, which guarantees bus turnaround. Then go to IDLE.
- Arbitration:
  - Default is fixed priority, CPU over monitor.
  - With `SRAM_ARB_RR_EN`, the arbiter round-robins; see Configuration.
- If a requester drops `req` before its `ack`:
  - The access still completes and `ack` still pulses.
  - A write is therefore never truncated.
- Request inputs are captured only in IDLE. Changes after the grant are ignored.
- A request made during another requester's access waits. It is evaluated in the next IDLE.

## Timing
- Latency from `req` seen high in IDLE (cycle 0) to `ack` is 2+`WAIT_CYCLES` cycles; this is cycle 6 with the default.
- Back-to-back throughput is one access per 4+`WAIT_CYCLES` cycles.
- `ack` is high for exactly one cycle. `req` must fall or be re-presented with new inputs afterwards; a `req` still high in the IDLE after `ack` starts a new access.
- Simultaneous `c_req` and `m_req` in IDLE: one is granted and the other is served immediately after, with no lost requests.
- Async reset mid-access:
  - Strobes go high and `dq_oe` goes to 0 without waiting for a clock edge.
  - No `ack` is issued.
  - The FSM restarts in IDLE.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - On a tie, the requester not granted last wins.
  - The last-grant register updates at every grant.
  - A continuously requesting CPU cannot starve the monitor: the monitor waits at most one access.
- Undefined: strict CPU priority, and the last-grant register is not built. The monitor is served only when `c_req` is low in IDLE.

## Structure
- Shared package `sram_pkg`:
  - The state encoding: IDLE, SETUP, ACCESS, DONE, TURN.
  - Grant codes: NONE, CPU, MON.
  - Default constants `SRAM_ADDR_W`=18 and `SRAM_WAIT_CYCLES`=4.
- One sub-module, `sram_arb_pick`: the combinational/registered grant selector, holding the priority/RR logic and the last-grant register. The FSM and strobe timing stay in `sram_arbiter`.

## Test plan
- CPU write 0x5A to 0x04082, then CPU read of 0x04082 → `c_rdata`=0x5A. During the write `we_n` is low for exactly 4 cycles. `c_ack` arrives 6 cycles after `req`.
- Monitor read of 0x00000 after a preload of 0xC3 → `m_rdata`=0xC3. `dq_oe` stays 0 throughout.
- `c_req` and `m_req` rise on the same cycle:
  - Both builds: CPU acked first, then monitor acked 8 cycles later.
  - RR build: with both held continuously, grants alternate C, M, C, M.
  - Non-RR build: a held `c_req` locks out the monitor.
- `c_req` dropped in the SETUP cycle of a write to 0x3FFFF → write completes, `c_ack` pulses once, no second access.
- `reset_n` asserted during ACCESS of a write → `we_n`/`ce_n` high and `dq_oe` 0 in the same cycle. No `ack`. `busy`=0 after reset.
- Turnaround check → every DONE cycle is followed by a cycle with `ce_n`=1 and `dq_oe`=0 before the next SETUP.
